// File: rtl/pwm_gen_dt.sv
`default_nettype none
//==============================================================================
// pwm_gen_dt - center-aligned three-leg PWM with per-leg dead-time insertion;
// define PWM_GEN_PERIOD_IRQ_EN to add a 500-cycle IRQ pulse after each zero.
// Revision: 1.0
//==============================================================================
module pwm_gen_dt #(
  parameter int CW       = 16,
  parameter int PERIOD   = 2500,
  parameter int DEADTIME = 100
) (
  input  logic          CLK0,
  input  logic          RST,
  input  logic          WR,
  input  logic [1:0]    WADDR,
  input  logic [CW-1:0] WDATA,
  output logic [5:0]    PWM,
  output logic          ZERO,
  output logic [CW-1:0] CNT
`ifdef PWM_GEN_PERIOD_IRQ_EN
  ,
  output logic          IRQ
`endif
);

  localparam int              DTW     = (DEADTIME < 2) ? 1 : $clog2(DEADTIME + 1);
  localparam logic [CW-1:0]   PEAK    = CW'(PERIOD);
  localparam logic [DTW-1:0]  DT_LOAD = DTW'(DEADTIME);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [1:0]    ctrl;
  logic [1:0]    ctrl_nxt;
  logic          run;
  logic          blocked_nxt;
  logic          blocked_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  dir_t          dir;
  dir_t          dir_nxt;
  logic [2:0]    leg_hi;
  logic [2:0]    leg_lo;

  // Control writes act on the sampling edge, so gating looks at the next value.
  assign ctrl_nxt    = (WR && (WADDR == 2'd3)) ? WDATA[1:0] : ctrl;
  assign run         = ctrl[0];
  assign blocked_nxt = !ctrl_nxt[0] || ctrl_nxt[1];
  assign blocked_q   = !ctrl[0] || ctrl[1];

  always_ff @(posedge CLK0 or posedge RST) begin
    if (RST) begin
      ctrl <= 2'b00;
      cnt  <= '0;
      dir  <= DIR_UP;
    end else begin
      ctrl <= ctrl_nxt;
      cnt  <= cnt_nxt;
      dir  <= dir_nxt;
    end
  end

  // Counter holds at zero for the first running cycle so ZERO is visible then.
  always_comb begin
    cnt_nxt = '0;
    dir_nxt = DIR_UP;
    if (ctrl_nxt[0] && run) begin
      cnt_nxt = cnt;
      dir_nxt = dir;
      case (dir)
        DIR_UP: begin
          if (cnt == PEAK) begin
            cnt_nxt = PEAK - CW'(1);
            dir_nxt = DIR_DOWN;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          if (cnt == CW'(1)) begin
            cnt_nxt = '0;
            dir_nxt = DIR_UP;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
      endcase
    end
  end

  assign ZERO = run && (cnt == '0);
  assign CNT  = cnt;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_leg
      logic [CW-1:0]  shadow;
      logic [CW-1:0]  active;
      logic           h;
      logic           h_prev;
      logic [DTW-1:0] dt;
      logic           hi;
      logic           lo;

      assign h = (cnt < active);

      always_ff @(posedge CLK0 or posedge RST) begin
        if (RST) begin
          shadow <= '0;
          active <= '0;
          h_prev <= 1'b0;
          dt     <= '0;
          hi     <= 1'b0;
          lo     <= 1'b0;
        end else begin
          if (WR && (WADDR == 2'(g))) begin
            shadow <= WDATA;
          end
          if (!run || (cnt == '0)) begin
            active <= shadow;
          end
          h_prev <= h;
          // Leaving a blocked state counts as a transition: full dead-time first.
          if (blocked_nxt || blocked_q || (h != h_prev)) begin
            dt <= DT_LOAD;
            hi <= 1'b0;
            lo <= 1'b0;
          end else if (dt > DTW'(1)) begin
            dt <= dt - DTW'(1);
            hi <= 1'b0;
            lo <= 1'b0;
          end else begin
            dt <= '0;
            hi <= h;
            lo <= !h;
          end
        end
      end

      assign leg_hi[g] = hi;
      assign leg_lo[g] = lo;
    end
  endgenerate

  assign PWM = {leg_lo[2], leg_hi[2], leg_lo[1], leg_hi[1], leg_lo[0], leg_hi[0]};

`ifdef PWM_GEN_PERIOD_IRQ_EN
  localparam int IRQ_LEN = 500;

  logic [8:0] irq_cnt;

  always_ff @(posedge CLK0 or posedge RST) begin
    if (RST) begin
      irq_cnt <= '0;
    end else if (ZERO) begin
      irq_cnt <= 9'(IRQ_LEN);
    end else if (irq_cnt != '0) begin
      irq_cnt <= irq_cnt - 9'd1;
    end
  end

  assign IRQ = (irq_cnt != '0);
`else
  // Period interrupt not built in this configuration.
`endif

endmodule
`default_nettype wire
